// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives enable/flush lines for the PC and
// the four pipeline registers (load-use, branch, multiply, memory wait).
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rd_addr,
    input  logic                   ex_branch_taken,
    input  logic                   ex_mul_start,
    input  logic                   mem_wait,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_MUL = 2'd1
    } state_t;

    localparam logic [3:0] MUL_INIT =
        (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;
    localparam logic MUL_ON = (MUL_LATENCY > 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [STALL_CNT_W-1:0] r_stall;

    state_t     w_nstate;
    logic [3:0] w_ncnt;
    logic [4:0] w_en;
    logic [2:0] w_fl;
    logic       w_load_use;
    logic       w_mul_go;

    assign w_load_use = ex_mem_read && (ex_rd_addr != '0) &&
                        ((ex_rd_addr == id_rs1_addr) ||
                         (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
    assign w_mul_go   = ex_mul_start && MUL_ON;

    // Enable order: pc, if_id, id_ex, ex_mem, mem_wb; flush: if_id, id_ex, ex_mem
    always_comb begin
        w_en     = 5'b11111;
        w_fl     = 3'b000;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        if (!rst_n) begin
            w_en = 5'b00000;
            w_fl = 3'b111;
        end else if (mem_wait) begin
            w_en = 5'b00000;
        end else if (r_state == S_MUL) begin
            if (r_cnt != 4'd0) begin
                w_en   = 5'b00011;
                w_fl   = 3'b001;
                w_ncnt = r_cnt - 4'd1;
            end else begin
                w_nstate = S_RUN;
            end
        end else if (w_mul_go) begin
            w_en     = 5'b00011;
            w_fl     = 3'b001;
            w_nstate = S_MUL;
            w_ncnt   = MUL_INIT;
        end else if (ex_branch_taken) begin
            w_fl = 3'b110;
        end else if (w_load_use) begin
            w_en = 5'b00111;
            w_fl = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
            r_stall <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (!w_en[4] && (r_stall != '1))
                r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign pc_en        = w_en[4];
    assign if_id_en     = w_en[3];
    assign id_ex_en     = w_en[2];
    assign ex_mem_en    = w_en[1];
    assign mem_wb_en    = w_en[0];
    assign if_id_flush  = w_fl[2];
    assign id_ex_flush  = w_fl[1];
    assign ex_mem_flush = w_fl[0];
    assign ctrl_state   = r_state;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected output vectors are
// queued as each cycle's stimulus is driven and popped when sampled.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        ex_mul_start, mem_wait;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_err = 0;

    // {pc,if_id,id_ex,ex_mem,mem_wb, fl_if_id,fl_id_ex,fl_ex_mem}
    localparam logic [7:0] V_NORM = 8'b11111_000;
    localparam logic [7:0] V_LU   = 8'b00111_010;
    localparam logic [7:0] V_MUL  = 8'b00011_001;
    localparam logic [7:0] V_BR   = 8'b11111_110;
    localparam logic [7:0] V_FRZ  = 8'b00000_000;
    localparam logic [7:0] V_RST  = 8'b00000_111;

    typedef struct {
        logic [7:0] v;
        logic [1:0] st;
        string      tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MUL_LATENCY(4),
        .STALL_CNT_W(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs2    (id_uses_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd_addr     (ex_rd_addr),
        .ex_branch_taken(ex_branch_taken),
        .ex_mul_start   (ex_mul_start),
        .mem_wait       (mem_wait),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .ctrl_state     (ctrl_state),
        .stall_cycles   (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        logic [7:0] got;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
            return;
        end
        e   = q.pop_front();
        got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush};
        chk({e.tag, ".out"}, 32'(got), 32'(e.v));
        chk({e.tag, ".st"}, 32'(ctrl_state), 32'(e.st));
    endtask

    task automatic step(input string tag,
                        input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic br, input logic mul,
                        input logic mw,
                        input logic [7:0] ev, input logic [1:0] es);
        @(negedge clk);
        ex_mem_read     = mr;
        ex_rd_addr      = rd;
        id_rs1_addr     = rs1;
        id_rs2_addr     = rs2;
        id_uses_rs2     = u2;
        ex_branch_taken = br;
        ex_mul_start    = mul;
        mem_wait        = mw;
        q.push_back('{ev, es, tag});
        #1;
        pop_cmp();
    endtask

    task automatic idle(input string tag, input logic [1:0] es);
        step(tag, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, V_NORM, es);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        ex_mul_start = 0; mem_wait = 0;

        repeat (2) @(negedge clk);
        #1;
        q.push_back('{V_RST, 2'd0, "reset"});
        pop_cmp();
        chk("reset.stall", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle("idle0", 2'd0);
        chk("idle0.stall", stall_cycles, 32'd0);

        step("lu_rs1", 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0, V_LU, 2'd0);
        idle("lu_after", 2'd0);
        chk("lu.stall", stall_cycles, 32'd1);

        step("lu_x0", 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, V_NORM, 2'd0);
        idle("lu_x0_after", 2'd0);
        chk("lu_x0.stall", stall_cycles, 32'd1);

        step("rs2_unused", 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, V_NORM, 2'd0);
        step("rs2_used", 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, V_LU, 2'd0);
        idle("rs2_after", 2'd0);
        chk("rs2.stall", stall_cycles, 32'd2);

        step("br_lu", 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0, V_BR, 2'd0);
        idle("br_after", 2'd0);
        chk("br.stall", stall_cycles, 32'd2);

        step("mul_t0", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd0);
        step("mul_t1", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mul_t2", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mul_t3", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_NORM, 2'd1);
        step("mul2_t4", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd0);
        step("mul2_t5", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mul2_t6", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mul2_t7", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_NORM, 2'd1);
        idle("mul_after", 2'd0);
        chk("mul.stall", stall_cycles, 32'd8);

        step("mw_t0", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd0);
        step("mw_t1", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_FRZ, 2'd1);
        step("mw_t2", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_FRZ, 2'd1);
        step("mw_t3", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mw_t4", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        step("mw_t5", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_NORM, 2'd1);
        idle("mw_after", 2'd0);
        chk("mw.stall", stall_cycles, 32'd13);

        step("rm_t0", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd0);
        step("rm_t1", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MUL, 2'd1);
        rst_n = 1'b0;
        #1;
        q.push_back('{V_RST, 2'd0, "rm_rst"});
        pop_cmp();
        chk("rm_rst.stall", stall_cycles, 32'd0);
        @(negedge clk);
        ex_mul_start = 0;
        rst_n = 1'b1;
        idle("rm_after0", 2'd0);
        idle("rm_after1", 2'd0);
        chk("rm.stall", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
